// File: rtl/mem_arbiter2_pkg.sv
// Shared bus definitions for the two-master memory arbiter: write-mask width,
// controller states and a small decode helper.
package mem_arbiter2_pkg;

    localparam int unsigned WMASK_W = 4;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } arb_state_e;

    // A zero byte mask marks a read; any set byte enable marks a write.
    function automatic logic is_write(input logic [WMASK_W-1:0] wmask);
        return |wmask;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// master that did not win last time. Holds the registered last-winner pointer.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_grant_valid,
    output logic       o_winner
);

    logic r_last;
    logic w_tie;

    assign w_tie         = &i_req;
    assign o_grant_valid = i_en & (|i_req);
    assign o_winner      = w_tie ? ~r_last : i_req[1];

    // Reset to m1 so that m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (o_grant_valid) begin
            r_last <= o_winner;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Shares one single-port word memory between two masters with round-robin grant.
// One transaction in flight; reads complete MEM_LAT cycles after the strobe.
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               m0_req,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [WMASK_W-1:0] m0_wmask,
    input  logic [DATA_W-1:0]  m0_wdata,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [DATA_W-1:0]  m0_rdata,

    input  logic               m1_req,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [WMASK_W-1:0] m1_wmask,
    input  logic [DATA_W-1:0]  m1_wdata,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [DATA_W-1:0]  m1_rdata,

    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rstrb,
    output logic [WMASK_W-1:0] mem_wmask,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    localparam int unsigned     LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    arb_state_e         r_state;
    logic               r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [LAT_W-1:0]   r_lat_cnt;

    logic               w_arb_en;
    logic               w_grant_valid;
    logic               w_winner;
    logic [ADDR_W-1:0]  w_addr;
    logic [WMASK_W-1:0] w_wmask;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_is_read;
    logic               w_rd_done;

    assign w_arb_en  = (r_state == StIdle);
    assign w_addr    = w_winner ? m1_addr  : m0_addr;
    assign w_wmask   = w_winner ? m1_wmask : m0_wmask;
    assign w_wdata   = w_winner ? m1_wdata : m0_wdata;
    assign w_is_read = ~is_write(w_wmask);
    assign w_rd_done = (r_state == StWait) && (r_lat_cnt == '0);

    rr_arbiter2 u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         ({m1_req, m0_req}),
        .i_en          (w_arb_en),
        .o_grant_valid (w_grant_valid),
        .o_winner      (w_winner)
    );

    // Writes complete in the grant cycle, so only reads leave StIdle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_lat_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant_valid) begin
                        r_owner <= w_winner;
                        r_addr  <= w_addr;
                        if (w_is_read) begin
                            r_state   <= StWait;
                            r_lat_cnt <= LAT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Grants and strobes are gated by rst_n so nothing leaks while reset is held.
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        mem_rstrb = 1'b0;
        mem_wmask = '0;
        mem_wdata = '0;
        mem_addr  = r_addr;
        if (rst_n) begin
            if (w_grant_valid) begin
                mem_addr = w_addr;
                m0_gnt   = ~w_winner;
                m1_gnt   = w_winner;
                if (w_is_read) begin
                    mem_rstrb = 1'b1;
                end else begin
                    mem_wmask = w_wmask;
                    mem_wdata = w_wdata;
                end
            end else if (w_rd_done) begin
                m0_rvalid = ~r_owner;
                m1_rvalid = r_owner;
            end
        end
    end

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

endmodule
